// File: rtl/hangman_pkg.sv
// -----------------------------------------------------------------------------
// hangman_pkg
// Shared definitions for the Hangman game controllers:
//   - 3-bit state type and the level-sequencer state codes
//   - letter code width and alphabet size
//   - word_width(): packed word width for a given letter count
// -----------------------------------------------------------------------------
package hangman_pkg;

  // Each letter of a word is a 5-bit code.
  localparam int LETTER_W = 5;

  // One mask bit per alphabet letter.
  localparam int ALPHA = 26;

  // Encoded FSM state, exposed on the block's state port.
  typedef logic [2:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t FETCH  = 3'd1;
  localparam state_t LOAD   = 3'd2;
  localparam state_t INGAME = 3'd3;
  localparam state_t WON    = 3'd4;
  localparam state_t LOST   = 3'd5;

  // Width of a packed word of 'letters' letter codes.
  function automatic int word_width(input int letters);
    return LETTER_W * letters;
  endfunction

endpackage

// File: rtl/start_edge_det.sv
// -----------------------------------------------------------------------------
// start_edge_det
// One-flop rising-edge detector. The flop's reset value is configurable so a
// level already high when reset is released can be treated as "not an edge".
//
// Ports:
//   clk    in   clock
//   reset  in   synchronous, active-high reset (flop <- RESET_VAL)
//   din    in   level to watch
//   rise   out  din & ~(din delayed one cycle); combinational pulse
// -----------------------------------------------------------------------------
module start_edge_det #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic din_q_r;

  // Delayed copy of din used to spot the low-to-high transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      din_q_r <= RESET_VAL;
    end else begin
      din_q_r <= din;
    end
  end

  assign rise = din & ~din_q_r;

endmodule

// File: rtl/level_sequencer.sv
// -----------------------------------------------------------------------------
// level_sequencer
// Hangman level controller. Fetches a level's packed {word, mask} from an
// external synchronous ROM (one-cycle read latency), holds it stable while a
// round runs, tracks the current level and a saturating win streak, and after
// a win either auto-advances to the next level or returns to player selection.
//
// Ports:
//   clk           in   clock
//   reset         in   synchronous, active-high reset
//   start_game    in   start/acknowledge; only its rising edge is used
//   win_game      in   round won  (looked at only in INGAME)
//   lost_game     in   round lost (looked at only in INGAME, win has priority)
//   auto_advance  in   1: a win leads to level+1, 0: a win returns to IDLE
//   select        in   player-chosen level, taken when leaving IDLE
//   rom_addr      out  ROM address, always the level register
//   rom_q         in   ROM data {word, mask}, valid one cycle after rom_addr
//   word          out  latched word
//   mask          out  latched mask
//   word_valid    out  word/mask belong to the current level (INGAME/WON/LOST)
//   level         out  current level
//   streak        out  consecutive wins, saturating
//   state         out  FSM state code
// -----------------------------------------------------------------------------
module level_sequencer #(
  parameter  int LETTERS  = 6,
  parameter  int ALPHA    = 26,
  parameter  int LEVELS   = 16,
  parameter  int STREAK_W = 4,
  localparam int ADDR_W   = (LEVELS > 1) ? $clog2(LEVELS) : 1,
  localparam int WORD_W   = hangman_pkg::word_width(LETTERS),
  localparam int ROM_W    = WORD_W + ALPHA
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_game,
  input  logic                win_game,
  input  logic                lost_game,
  input  logic                auto_advance,
  input  logic [ADDR_W-1:0]   select,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [ROM_W-1:0]    rom_q,
  output logic [WORD_W-1:0]   word,
  output logic [ALPHA-1:0]    mask,
  output logic                word_valid,
  output logic [ADDR_W-1:0]   level,
  output logic [STREAK_W-1:0] streak,
  output logic [2:0]          state
);

  import hangman_pkg::*;

  localparam logic [ADDR_W-1:0]   LAST_LEVEL = ADDR_W'(LEVELS - 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = {STREAK_W{1'b1}};

  state_t                state_r;
  state_t                next_state_s;
  logic                  start_edge_s;

  // Datapath strobes decoded from the current state.
  logic                  ld_select_s;
  logic                  adv_level_s;
  logic                  ld_data_s;
  logic                  clr_valid_s;
  logic                  inc_streak_s;
  logic                  clr_streak_s;

  logic [ADDR_W-1:0]     level_r;
  logic [WORD_W-1:0]     word_r;
  logic [ALPHA-1:0]      mask_r;
  logic                  valid_r;
  logic [STREAK_W-1:0]   streak_r;

  // A start held high through reset must not count as a request, so the
  // detector's history flop comes out of reset at 1.
  start_edge_det #(
    .RESET_VAL (1'b1)
  ) u_start_edge (
    .clk   (clk),
    .reset (reset),
    .din   (start_game),
    .rise  (start_edge_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_edge_s) begin
          next_state_s = FETCH;
        end else begin
          next_state_s = IDLE;
        end
      end
      // ROM samples rom_addr at the end of FETCH; its data is present in LOAD.
      FETCH:  next_state_s = LOAD;
      LOAD:   next_state_s = INGAME;
      INGAME: begin
        if (win_game) begin
          next_state_s = WON;
        end else if (lost_game) begin
          next_state_s = LOST;
        end else begin
          next_state_s = INGAME;
        end
      end
      WON: begin
        if (start_edge_s) begin
          if (auto_advance) begin
            next_state_s = FETCH;
          end else begin
            next_state_s = IDLE;
          end
        end else begin
          next_state_s = WON;
        end
      end
      LOST: begin
        if (start_edge_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = LOST;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Datapath control strobes.
  always_comb begin
    ld_select_s  = 1'b0;
    adv_level_s  = 1'b0;
    ld_data_s    = 1'b0;
    clr_valid_s  = 1'b0;
    inc_streak_s = 1'b0;
    clr_streak_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_edge_s) begin
          ld_select_s = 1'b1;
        end else begin
          ld_select_s = 1'b0;
        end
      end
      FETCH: begin
        ld_data_s = 1'b0;
      end
      LOAD: begin
        ld_data_s = 1'b1;
      end
      INGAME: begin
        // A loss alters no register here, so only the win path matters.
        if (win_game) begin
          inc_streak_s = 1'b1;
        end else begin
          inc_streak_s = 1'b0;
        end
      end
      WON: begin
        if (start_edge_s) begin
          clr_valid_s = 1'b1;
          adv_level_s = auto_advance;
        end else begin
          clr_valid_s = 1'b0;
        end
      end
      LOST: begin
        if (start_edge_s) begin
          clr_valid_s  = 1'b1;
          clr_streak_s = 1'b1;
        end else begin
          clr_valid_s  = 1'b0;
        end
      end
      default: begin
        clr_valid_s = 1'b1;
      end
    endcase
  end

  // Level register; advance wraps explicitly so non-power-of-two LEVELS works.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_r <= '0;
    end else if (ld_select_s) begin
      level_r <= select;
    end else if (adv_level_s) begin
      if (level_r == LAST_LEVEL) begin
        level_r <= '0;
      end else begin
        level_r <= level_r + ADDR_W'(1);
      end
    end else begin
      level_r <= level_r;
    end
  end

  // Word/mask latch; held until the next LOAD, qualified by valid_r.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_r <= '0;
      mask_r <= '0;
    end else if (ld_data_s) begin
      word_r <= rom_q[ROM_W-1:ALPHA];
      mask_r <= rom_q[ALPHA-1:0];
    end else begin
      word_r <= word_r;
      mask_r <= mask_r;
    end
  end

  // Data-valid flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= 1'b0;
    end else if (ld_data_s) begin
      valid_r <= 1'b1;
    end else if (clr_valid_s) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Win streak, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      streak_r <= '0;
    end else if (clr_streak_s) begin
      streak_r <= '0;
    end else if (inc_streak_s && (streak_r != STREAK_MAX)) begin
      streak_r <= streak_r + STREAK_W'(1);
    end else begin
      streak_r <= streak_r;
    end
  end

  assign rom_addr   = level_r;
  assign level      = level_r;
  assign word       = word_r;
  assign mask       = mask_r;
  assign word_valid = valid_r;
  assign streak     = streak_r;
  assign state      = state_r;

endmodule
